// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo matching pipeline: census window sizing,
// image geometry and cost-width helpers common to the windower and matcher.
package stereo_pkg;

    // Ceiling log2 for elaboration-time width derivation (clog2(1) == 0).
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // A census window contributes one 8-bit comparison byte per pixel.
    function automatic int vec_width(input int wndw_sz);
        return wndw_sz * wndw_sz * 32'sd8;
    endfunction

    localparam int CENSUS_WNDW_SZ = 3;
    localparam int IMG_ROW_SZ     = 320;
    localparam int IMG_COL_SZ     = 240;
    localparam int COORD_W        = 10;
    localparam int DEF_MAX_DISP   = 32;

    localparam int DEF_VEC_W  = vec_width(CENSUS_WNDW_SZ);
    localparam int DEF_DISP_W = clog2(DEF_MAX_DISP);
    localparam int DEF_COST_W = clog2(DEF_VEC_W + 1);

    // Cost assigned to a disabled candidate; larger than any real Hamming cost.
    localparam logic [DEF_COST_W-1:0] COST_MAX = {DEF_COST_W{1'b1}};

endpackage

// File: rtl/hamming_popcount.sv
// Purely combinational population count of a census XOR difference vector.
module hamming_popcount #(
    parameter int VEC_W  = 72,
    parameter int COST_W = 7
) (
    input  logic [VEC_W-1:0]  diff,
    output logic [COST_W-1:0] cost
);

    // Sum the set bits of the difference vector.
    always_comb begin
        cost = {COST_W{1'b0}};
        for (int i = 0; i < VEC_W; i++) begin
            cost = cost + COST_W'(diff[i]);
        end
    end

endmodule

// File: rtl/census_disparity.sv
// Winner-take-all disparity search over a census-vector stream.
// A shift register of past right windows supplies candidates d=1..MAX_DISP-1;
// the live right window is candidate 0. Three register stages: costs,
// per-group-of-8 argmin, final argmin driving the outputs.
module census_disparity
    import stereo_pkg::*;
#(
    parameter  int WNDW_SZ  = CENSUS_WNDW_SZ,
    parameter  int MAX_DISP = DEF_MAX_DISP,
    parameter  int ROW_SZ   = IMG_ROW_SZ,
    parameter  int DISP_W   = 5,
    parameter  int COST_W   = 7,
    localparam int VEC_W    = vec_width(WNDW_SZ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [VEC_W-1:0]    l_val,
    input  logic [VEC_W-1:0]    r_val,
    input  logic [COORD_W-1:0]  in_x,
    input  logic [COORD_W-1:0]  in_y,
    input  logic                is_in_val,
    output logic [DISP_W-1:0]   out_disp,
    output logic [COST_W-1:0]   out_cost,
    output logic [COORD_W-1:0]  out_x,
    output logic [COORD_W-1:0]  out_y,
    output logic                is_out_val
);

    localparam int HIST_N = MAX_DISP - 1;
    localparam int GRP_SZ = (MAX_DISP < 8) ? MAX_DISP : 8;
    localparam int NGRP   = MAX_DISP / GRP_SZ;
    localparam logic [COST_W-1:0] COST_ALL = {COST_W{1'b1}};

    // Reject parameter sets the datapath cannot represent.
    if ((DISP_W != clog2(MAX_DISP)) || (COST_W < clog2(VEC_W + 1)) ||
        (MAX_DISP < 2) || (MAX_DISP > 64) || ((MAX_DISP & (MAX_DISP - 1)) != 0) ||
        (ROW_SZ < 1) || (ROW_SZ > (1 << COORD_W))) begin : g_param_err
        $error("census_disparity: inconsistent parameters");
    end

    // ---------------- right-window history ----------------
    logic [VEC_W-1:0]  hist_q [HIST_N];
    logic [VEC_W-1:0]  hist_d [HIST_N];
    logic [HIST_N-1:0] hist_vld_q;
    logic [HIST_N-1:0] hist_vld_d;

    // Shift the live right window into the history on each strobe, else hold.
    always_comb begin
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
        if (is_in_val) begin
            hist_d[0]     = r_val;
            hist_vld_d[0] = 1'b1;
            for (int k = 1; k < HIST_N; k++) begin
                hist_d[k]     = hist_q[k-1];
                hist_vld_d[k] = hist_vld_q[k-1];
            end
        end else begin
            hist_d     = hist_q;
            hist_vld_d = hist_vld_q;
        end
    end

    // History data needs no reset; only its valid bits are cleared.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    // History valid bits: cleared on reset so stale windows never compete.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_vld_q <= {HIST_N{1'b0}};
        end else begin
            hist_vld_q <= hist_vld_d;
        end
    end

    // ---------------- candidate costs ----------------
    logic [COST_W-1:0] pc_s [MAX_DISP];
    logic [MAX_DISP-1:0] en_s;

    for (genvar d = 0; d < MAX_DISP; d++) begin : g_cand
        logic [VEC_W-1:0] cand_s;
        if (d == 0) begin : g_d0
            assign cand_s = r_val;
            assign en_s[d] = 1'b1;
        end else begin : g_dn
            // A candidate must lie inside the current row and be real data.
            assign cand_s = hist_q[d-1];
            assign en_s[d] = (in_x >= COORD_W'(d)) && hist_vld_q[d-1];
        end
        hamming_popcount #(
            .VEC_W  (VEC_W),
            .COST_W (COST_W)
        ) u_popcount (
            .diff (l_val ^ cand_s),
            .cost (pc_s[d])
        );
    end

    // ---------------- S1: registered costs ----------------
    logic [COST_W-1:0]  cost_d [MAX_DISP];
    logic [COST_W-1:0]  cost_q [MAX_DISP];
    logic               v1_d, v1_q;
    logic [COORD_W-1:0] x1_d, x1_q, y1_d, y1_q;

    // Force disabled candidates to the maximum cost so they can never win.
    always_comb begin
        v1_d = is_in_val;
        x1_d = in_x;
        y1_d = in_y;
        for (int d = 0; d < MAX_DISP; d++) begin
            if (en_s[d]) begin
                cost_d[d] = pc_s[d];
            end else begin
                cost_d[d] = COST_ALL;
            end
        end
    end

    // ---------------- S2: per-group argmin ----------------
    logic [COST_W-1:0]  min2_d [NGRP];
    logic [COST_W-1:0]  min2_q [NGRP];
    logic [DISP_W-1:0]  arg2_d [NGRP];
    logic [DISP_W-1:0]  arg2_q [NGRP];
    logic               v2_d, v2_q;
    logic [COORD_W-1:0] x2_d, x2_q, y2_d, y2_q;

    // Ascending scan with strict less-than keeps the lowest disparity on ties.
    always_comb begin
        v2_d = v1_q;
        x2_d = x1_q;
        y2_d = y1_q;
        for (int g = 0; g < NGRP; g++) begin
            min2_d[g] = cost_q[g*GRP_SZ];
            arg2_d[g] = DISP_W'(g * GRP_SZ);
            for (int j = 1; j < GRP_SZ; j++) begin
                if (cost_q[g*GRP_SZ + j] < min2_d[g]) begin
                    min2_d[g] = cost_q[g*GRP_SZ + j];
                    arg2_d[g] = DISP_W'(g * GRP_SZ + j);
                end else begin
                    min2_d[g] = min2_d[g];
                    arg2_d[g] = arg2_d[g];
                end
            end
        end
    end

    // ---------------- S3: final argmin and outputs ----------------
    logic [COST_W-1:0]  fin_cost_s;
    logic [DISP_W-1:0]  fin_disp_s;
    logic [DISP_W-1:0]  out_disp_d, out_disp_q;
    logic [COST_W-1:0]  out_cost_d, out_cost_q;
    logic [COORD_W-1:0] out_x_d, out_x_q, out_y_d, out_y_q;
    logic               out_val_d, out_val_q;

    // Merge group winners, lower group preferred on ties; hold when idle.
    always_comb begin
        fin_cost_s = min2_q[0];
        fin_disp_s = arg2_q[0];
        for (int g = 1; g < NGRP; g++) begin
            if (min2_q[g] < fin_cost_s) begin
                fin_cost_s = min2_q[g];
                fin_disp_s = arg2_q[g];
            end else begin
                fin_cost_s = fin_cost_s;
                fin_disp_s = fin_disp_s;
            end
        end
        out_val_d = v2_q;
        if (v2_q) begin
            out_disp_d = fin_disp_s;
            out_cost_d = fin_cost_s;
            out_x_d    = x2_q;
            out_y_d    = y2_q;
        end else begin
            out_disp_d = out_disp_q;
            out_cost_d = out_cost_q;
            out_x_d    = out_x_q;
            out_y_d    = out_y_q;
        end
    end

    // Pipeline datapath registers; validity is tracked separately.
    always_ff @(posedge clk) begin
        cost_q <= cost_d;
        x1_q   <= x1_d;
        y1_q   <= y1_d;
        min2_q <= min2_d;
        arg2_q <= arg2_d;
        x2_q   <= x2_d;
        y2_q   <= y2_d;
    end

    // Stage valids and outputs: reset drops in-flight results and clears outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            out_val_q  <= 1'b0;
            out_disp_q <= {DISP_W{1'b0}};
            out_cost_q <= {COST_W{1'b0}};
            out_x_q    <= {COORD_W{1'b0}};
            out_y_q    <= {COORD_W{1'b0}};
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            out_val_q  <= out_val_d;
            out_disp_q <= out_disp_d;
            out_cost_q <= out_cost_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
        end
    end

    assign out_disp   = out_disp_q;
    assign out_cost   = out_cost_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign is_out_val = out_val_q;

endmodule

// File: tb/tb_census_disparity.sv
// Self-checking bench for census_disparity: a queue-based reference model
// predicts each result and the cycle it must appear on.
module tb_census_disparity;

    logic        clk;
    logic        reset;
    logic [71:0] l_val, r_val;
    logic [9:0]  in_x, in_y;
    logic        is_in_val;
    logic [4:0]  out_disp;
    logic [6:0]  out_cost;
    logic [9:0]  out_x, out_y;
    logic        is_out_val;

    census_disparity dut (
        .clk        (clk),
        .reset      (reset),
        .l_val      (l_val),
        .r_val      (r_val),
        .in_x       (in_x),
        .in_y       (in_y),
        .is_in_val  (is_in_val),
        .out_disp   (out_disp),
        .out_cost   (out_cost),
        .out_x      (out_x),
        .out_y      (out_y),
        .is_out_val (is_out_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] disp;
        logic [6:0] cost;
        logic [9:0] x;
        logic [9:0] y;
    } res_t;

    typedef struct {
        int   due;
        res_t r;
    } pend_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [71:0] rhist[$];
    pend_t       pend[$];
    res_t        hold = '0;
    res_t        e, o;

    // Reference: scan every in-row disparity with real history, keep first minimum.
    function automatic res_t predict(input logic [71:0] l, input logic [71:0] r,
                                     input logic [9:0] x, input logic [9:0] y);
        res_t p;
        int best_c, best_d, c;
        best_c = 1 << 30;
        best_d = 0;
        for (int d = 0; d < 32; d++) begin
            c = -1;
            if (d == 0) c = $countones(l ^ r);
            else if (d <= int'(x) && d <= rhist.size()) c = $countones(l ^ rhist[d-1]);
            if (c >= 0 && c < best_c) begin
                best_c = c;
                best_d = d;
            end
        end
        p.v = 1'b1; p.disp = 5'(best_d); p.cost = 7'(best_c); p.x = x; p.y = y;
        return p;
    endfunction

    // What the outputs must show on the current cycle.
    function automatic res_t expect_now();
        res_t r;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend[0].r;
            void'(pend.pop_front());
            hold = r;
        end else begin
            r = hold;
            r.v = 1'b0;
        end
        return r;
    endfunction

    function automatic res_t observe();
        res_t r;
        r.v = is_out_val; r.disp = out_disp; r.cost = out_cost; r.x = out_x; r.y = out_y;
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("v=%0b d=%0d c=%0d x=%0d y=%0d", r.v, r.disp, r.cost, r.x, r.y);
    endfunction

    function automatic logic [71:0] rnd72();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Drive one cycle of inputs, update the model, advance to just after the edge.
    task automatic apply(input logic rst, input logic stb, input logic [71:0] l,
                         input logic [71:0] r, input logic [9:0] x, input logic [9:0] y);
        reset = rst; is_in_val = stb; l_val = l; r_val = r; in_x = x; in_y = y;
        if (rst) begin
            pend.delete();
            rhist.delete();
            hold = '0;
        end else if (stb) begin
            pend.push_back('{cyc + 3, predict(l, r, x, y)});
            rhist.push_front(r);
            if (rhist.size() > 31) void'(rhist.pop_back());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, rnd72(), rnd72(), 10'd0, 10'd0);
            e = expect_now(); o = observe(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL reset got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_identity();
        logic [71:0] v;
        for (int x = 0; x < 323; x++) begin
            v = rnd72();
            apply(1'b0, x < 320, v, v, 10'(x), 10'd0);
            e = expect_now(); o = observe(); vectors++;
            if (o !== e || (e.v && (o.disp !== 5'd0 || o.cost !== 7'd0))) begin
                miscompares++; $display("FAIL identity got %s want %s", fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_shift();
        logic [71:0] rs[$];
        logic [71:0] l;
        for (int x = 0; x < 67; x++) begin
            rs.push_back(rnd72());
            l = (x >= 5) ? rs[x-5] : rnd72();
            apply(1'b0, x < 64, l, rs[x], 10'(x), 10'd1);
            e = expect_now(); o = observe(); vectors++;
            if (o !== e || (e.v && e.x >= 10'd5 && (o.disp !== 5'd5 || o.cost !== 7'd0))) begin
                miscompares++; $display("FAIL shift got %s want %s", fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_row_start();
        logic [71:0] p;
        p = rnd72();
        for (int i = 0; i < 37; i++) begin
            if (i < 31)       apply(1'b0, 1'b1, rnd72(), p, 10'(289 + i), 10'd2);
            else if (i < 33)  apply(1'b0, 1'b1, rnd72(), rnd72(), 10'(i - 31), 10'd3);
            else if (i == 33) apply(1'b0, 1'b1, p, rnd72(), 10'd2, 10'd3);
            else              apply(1'b0, 1'b0, rnd72(), rnd72(), 10'd0, 10'd0);
            e = expect_now(); o = observe(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL row_start got %s want %s", fmt(o), fmt(e)); end
        end
        vectors++;
        if (out_disp > 5'd2 || out_x !== 10'd2 || out_y !== 10'd3) begin
            miscompares++; $display("FAIL row_start_range got d=%0d x=%0d want d<=2 x=2", out_disp, out_x);
        end
    endtask

    task automatic test_tie();
        logic [71:0] b, r;
        b = rnd72();
        for (int x = 0; x < 13; x++) begin
            if (x == 0)      r = b ^ 72'h3C00;
            else if (x == 6) r = b ^ 72'hF;
            else             r = ~b;
            apply(1'b0, x < 10, (x == 9) ? b : rnd72(), r, 10'(x), 10'd4);
            e = expect_now(); o = observe(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL tie got %s want %s", fmt(o), fmt(e)); end
        end
        vectors++;
        if (out_disp !== 5'd3 || out_cost !== 7'd4) begin
            miscompares++; $display("FAIL tie_winner got d=%0d c=%0d want d=3 c=4", out_disp, out_cost);
        end
    endtask

    task automatic test_all_mismatch();
        for (int x = 0; x < 44; x++) begin
            apply(1'b0, x < 41, {72{1'b1}}, 72'd0, 10'(x), 10'd5);
            e = expect_now(); o = observe(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL all_mismatch got %s want %s", fmt(o), fmt(e)); end
        end
        vectors++;
        if (out_disp !== 5'd0 || out_cost !== 7'd72) begin
            miscompares++; $display("FAIL all_mismatch_final got d=%0d c=%0d want d=0 c=72", out_disp, out_cost);
        end
    endtask

    task automatic test_bubbles_reset();
        logic [71:0] r, l, v;
        int s, gap;
        for (int x = 0; x < 40; x++) begin
            r = rnd72();
            s = $urandom_range(0, 31);
            if (s == 0) l = r;
            else if (s <= x && s <= rhist.size()) l = rhist[s-1];
            else l = rnd72();
            apply(1'b0, 1'b1, l, r, 10'(x), 10'd6);
            e = expect_now(); o = observe(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL bubbles got %s want %s", fmt(o), fmt(e)); end
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                apply(1'b0, 1'b0, rnd72(), rnd72(), 10'd0, 10'd0);
                e = expect_now(); o = observe(); vectors++;
                if (o !== e) begin miscompares++; $display("FAIL bubbles_gap got %s want %s", fmt(o), fmt(e)); end
            end
        end
        // Reset lands while the last pixel sits between S1 and S3.
        for (int i = 0; i < 9; i++) begin
            v = rnd72();
            if (i == 0)      apply(1'b0, 1'b1, rnd72(), rnd72(), 10'd40, 10'd6);
            else if (i == 1) apply(1'b1, 1'b0, rnd72(), rnd72(), 10'd0, 10'd0);
            else if (i == 3) apply(1'b0, 1'b1, v, v, 10'd0, 10'd7);
            else if (i == 4) apply(1'b0, 1'b1, rnd72(), rnd72(), 10'd1, 10'd7);
            else             apply(1'b0, 1'b0, rnd72(), rnd72(), 10'd0, 10'd0);
            e = expect_now(); o = observe(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL reset_mid step=%0d got %s want %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] r, l;
        int s, x, y;
        logic stb;
        x = 300; y = 8;
        for (int i = 0; i < 203; i++) begin
            stb = (i < 200) && ($urandom_range(0, 9) < 8);
            r = rnd72();
            s = $urandom_range(0, 31);
            if (s == 0) l = r;
            else if (s <= x && s <= rhist.size()) l = rhist[s-1] ^ (72'd1 << $urandom_range(0, 71));
            else l = rnd72();
            apply(1'b0, stb, l, r, 10'(x), 10'(y));
            if (stb) begin
                x++;
                if (x == 320) begin x = 0; y++; end
            end
            e = expect_now(); o = observe(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL back_to_back got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    initial begin
        reset = 1'b1; is_in_val = 1'b0; l_val = '0; r_val = '0; in_x = '0; in_y = '0;
        test_reset();
        test_identity();
        test_shift();
        test_row_start();
        test_tie();
        test_all_mismatch();
        test_bubbles_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/census_disparity.md
Name: census_disparity

Overview:
- Matching stage directly downstream of the census windower.
- Consumes two lockstep window streams, left and right, each a concatenated census vector with its pixel X/Y and a valid strobe.
- For each left pixel it computes the Hamming cost against the right windows at disparities 0..MAX_DISP-1 and selects the lowest cost (winner-take-all).
- Emits disparity, cost and pixel coordinates to the depth-map writer.

Parameters:
- WNDW_SZ, 3: census window edge; VEC_W = WNDW_SZ*WNDW_SZ*8 (72 at default).
- MAX_DISP, 32: number of disparity candidates, power of two, 2..64.
- ROW_SZ, 320: pixels per row; bounds valid x.
- DISP_W, 5: width of disparity output; must equal clog2(MAX_DISP).
- COST_W, 7: cost width; must be at least clog2(VEC_W+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- l_val  in  VEC_W  left window census vector
- r_val  in  VEC_W  right window census vector, same pixel position as l_val
- in_x  in  10  column of current window centre
- in_y  in  10  row of current window centre
- is_in_val  in  1  single-cycle strobe; l_val, r_val, in_x, in_y are valid
- out_disp  out  DISP_W  winning disparity
- out_cost  out  COST_W  Hamming cost of the winner
- out_x  out  10  column of the result
- out_y  out  10  row of the result
- is_out_val  out  1  single-cycle result strobe

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high, and clears all valid bits, out_disp, out_cost, out_x, out_y and is_out_val to 0.
- History buffer: MAX_DISP-1 entries of VEC_W, each with a valid bit. On is_in_val, hist[0] <= r_val, hist[k] <= hist[k-1], and the valid bits shift the same way with a 1 inserted. With no strobe the buffer holds. Reset clears the valid bits only.
- Candidates: candidate d=0 is r_val. Candidate d>=1 is hist[d-1].
- Candidate enable: d is enabled iff d <= in_x and (d==0 or hist valid[d-1]). This excludes previous-row and pre-reset data at row starts.
- Cost: cost[d] = popcount(l_val XOR cand[d]). A disabled candidate is forced to all-ones (2^COST_W-1) and can never win against an enabled one.
- Candidate d=0 is always enabled.
- Pipeline: fixed latency, free-running, not stalled by is_in_val gaps. Each stage carries valid, x and y.
  - S1, cycle after strobe: registered cost[0..MAX_DISP-1].
  - S2: registered min/argmin per group of 8 candidates.
  - S3: registered final min/argmin across groups; this drives the outputs.
- is_out_val is asserted exactly 3 clocks after is_in_val. out_x = in_x and out_y = in_y of that input.
- Back-to-back strobes on every clock are supported at full throughput.
- Tie rule: the smallest disparity wins at every comparison level, using strict less-than with the lower-index operand preferred.
- Outputs hold their last values while is_out_val is low.
- Reset mid-operation: in-flight results are discarded and no is_out_val follows reset. History is treated as empty.
- No overflow is possible: COST_W covers VEC_W.

Decomposition:
- Shared package stereo_pkg holds:
  - VEC_W derivation (WNDW_SZ*WNDW_SZ*8);
  - clog2 function;
  - COST_MAX constant;
  - window/image size constants shared with the census windower.
- One sub-module, hamming_popcount (VEC_W in, COST_W out, combinational). It is instantiated MAX_DISP times in a generate loop.
- The argmin tree stays in this module.

Test Plan:
- Identity: l_val == r_val for every pixel, in_x runs 0..319 on a continuous strobe -> each result has out_disp=0, out_cost=0, and is_out_val arrives 3 clocks after each strobe.
- Known shift: right stream equals left stream delayed 5 pixels, with random vectors, in_x >= 5 -> out_disp=5, out_cost=0.
- Row start exclusion: true shift 5, in_x=2, history filled with the previous row's pixels identical to l_val -> out_disp is not 3..31; only d in 0..2 are considered.
- Tie: cost 4 at d=3 and d=9, all others greater -> out_disp=3, out_cost=4.
- All mismatch: l_val all-ones, r_val all-zeros everywhere -> out_cost=72, out_disp=0.
- Bubbles and reset: strobes separated by 0-4 idle cycles give correct disparities with latency 3. Asserting reset between S1 and S3 -> no is_out_val, outputs 0, and the next row's first pixel matches only d=0.
